// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the conv_layer_param convolution block:
//   - conv_state_t : controller state encoding
//   - CONV_N_DEF / CONV_M_DEF / CONV_T_DEF : default vector length, taps, width
//   - conv_sat     : clamps a wide signed accumulator to a t-bit signed range
// No ports (package).
// ---------------------------------------------------------------------------
package conv_pkg;

  localparam int CONV_N_DEF = 8;
  localparam int CONV_M_DEF = 4;
  localparam int CONV_T_DEF = 8;

  typedef enum logic [1:0] {
    ST_FLOAD = 2'd0,
    ST_FILL  = 2'd1,
    ST_MAC   = 2'd2,
    ST_OUT   = 2'd3
  } conv_state_t;

  // Input is wide enough for any legal accumulator (2*16 + 4 bits); the
  // result is returned in 16 bits and the caller keeps the low t bits.
  function automatic logic signed [15:0] conv_sat(input logic signed [47:0] v,
                                                  input int t);
    logic signed [47:0] hi;
    logic signed [47:0] lo;
    hi = (48'sd1 <<< (t - 1)) - 48'sd1;
    lo = -(48'sd1 <<< (t - 1));
    if (v > hi) begin
      conv_sat = hi[15:0];
    end else if (v < lo) begin
      conv_sat = lo[15:0];
    end else begin
      conv_sat = v[15:0];
    end
  endfunction

endpackage

// File: rtl/conv_layer_param_if.sv
// ---------------------------------------------------------------------------
// conv_layer_param_if
// Bundles the three valid/ready streams of conv_layer_param.
//   s_* : input samples      (source -> block)
//   f_* : filter coefficients (source -> block)
//   m_* : results            (block -> sink)
// Handshake: a word moves on a rising clock edge where valid and ready are
// both 1. A source holds data stable while valid is 1 and ready is 0; the
// block holds m_data_out/m_valid stable until the transfer.
// Modports: slave = the convolution block, master = the environment.
// ---------------------------------------------------------------------------
interface conv_layer_param_if #(parameter int T = 8);
  logic signed [T-1:0] s_data_in;
  logic                s_valid;
  logic                s_ready;
  logic signed [T-1:0] f_data_in;
  logic                f_valid;
  logic                f_ready;
  logic signed [T-1:0] m_data_out;
  logic                m_valid;
  logic                m_ready;

  modport slave (
    input  s_data_in, s_valid, f_data_in, f_valid, m_ready,
    output s_ready, f_ready, m_data_out, m_valid
  );

  modport master (
    output s_data_in, s_valid, f_data_in, f_valid, m_ready,
    input  s_ready, f_ready, m_data_out, m_valid
  );
endinterface

// File: rtl/conv_param_mem.sv
// ---------------------------------------------------------------------------
// conv_param_mem
// Single-write-port memory with a registered (1-cycle) read port.
// Ports:
//   clk      : clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address, sampled on the rising edge
//   rdata_o  : read data, valid the cycle after raddr_i is presented
// ---------------------------------------------------------------------------
module conv_param_mem #(
  parameter int DEPTH = 8,
  parameter int W     = 8,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/conv_layer_param.sv
// ---------------------------------------------------------------------------
// conv_layer_param
// 1-D valid convolution: loads M coefficients, then N samples, then emits
// y[i] = sat(sum_j x[i+j]*f[j]) for i = 0..N-M, one tap per cycle.
// Ports:
//   clk     : clock
//   reset   : asynchronous active-low reset
//   bus     : conv_layer_param_if.slave (s_*, f_*, m_* streams)
//   state_o : current controller state, for observation
// Optional feature: define CONV_LAYER_RELU_EN to replace negative saturated
// results by 0 before they are registered onto m_data_out.
// ---------------------------------------------------------------------------
module conv_layer_param
  import conv_pkg::*;
#(
  parameter int N = CONV_N_DEF,
  parameter int M = CONV_M_DEF,
  parameter int T = CONV_T_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  conv_layer_param_if.slave    bus,
  output conv_state_t          state_o
);

  localparam int SAW = (N > 1) ? $clog2(N) : 1;
  localparam int FAW = $clog2(M);
  localparam int KW  = $clog2(M + 2);
  localparam int AW  = 2 * T + $clog2(M);

  conv_state_t         state_q, state_d;
  logic                run_q;
  logic [FAW-1:0]      f_cnt_q, f_cnt_d;
  logic [SAW-1:0]      s_cnt_q, s_cnt_d;
  logic [SAW-1:0]      i_q, i_d;
  logic [KW-1:0]       k_q, k_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [T-1:0] out_q, out_d;

  logic                f_xfer, s_xfer, m_xfer;
  logic [SAW-1:0]      x_raddr;
  logic [FAW-1:0]      f_raddr, f_waddr;
  logic [T-1:0]        x_rdata, f_rdata;
  logic signed [2*T-1:0] prod;
  logic signed [15:0]  sat_full;
  logic signed [T-1:0] sat_t;

  // run_q delays f_ready by one edge after reset release, so the block only
  // starts accepting once reset deassertion has been seen synchronously.
  assign bus.f_ready = run_q && ((state_q == ST_FLOAD) ||
                                 (state_q == ST_FILL && s_cnt_q == '0));
  // With no samples yet, a pending coefficient takes priority over a sample.
  assign bus.s_ready = (state_q == ST_FILL) && !(s_cnt_q == '0 && bus.f_valid);
  assign bus.m_valid    = (state_q == ST_OUT);
  assign bus.m_data_out = out_q;
  assign state_o        = state_q;

  assign f_xfer = bus.f_valid && bus.f_ready;
  assign s_xfer = bus.s_valid && bus.s_ready;
  assign m_xfer = bus.m_valid && bus.m_ready;

  // A coefficient accepted in ST_FILL restarts the load at f[0].
  assign f_waddr = (state_q == ST_FLOAD) ? f_cnt_q : '0;
  // Tap k of output i is read during MAC cycle k; data arrives at cycle k+1.
  assign x_raddr = SAW'(32'(i_q) + 32'(k_q));
  assign f_raddr = FAW'(k_q);

  conv_param_mem #(.DEPTH(N), .W(T), .AW(SAW)) u_x_mem (
    .clk    (clk),
    .we_i   (s_xfer),
    .waddr_i(s_cnt_q),
    .wdata_i(bus.s_data_in),
    .raddr_i(x_raddr),
    .rdata_o(x_rdata)
  );

  conv_param_mem #(.DEPTH(M), .W(T), .AW(FAW)) u_f_mem (
    .clk    (clk),
    .we_i   (f_xfer),
    .waddr_i(f_waddr),
    .wdata_i(bus.f_data_in),
    .raddr_i(f_raddr),
    .rdata_o(f_rdata)
  );

  assign prod     = $signed(x_rdata) * $signed(f_rdata);
  assign sat_full = conv_sat(48'(acc_q), T);
  assign sat_t    = sat_full[T-1:0];

  // MAC cycle k = 0..M+1: k=0 issues the first read, k=1..M accumulate
  // taps 0..M-1, k=M+1 registers the result, giving M+2 cycles per output.
  always_comb begin
    state_d = state_q;
    f_cnt_d = f_cnt_q;
    s_cnt_d = s_cnt_q;
    i_d     = i_q;
    k_d     = k_q;
    acc_d   = acc_q;
    out_d   = out_q;
    case (state_q)
      ST_FLOAD: begin
        if (f_xfer) begin
          if (f_cnt_q == FAW'(M - 1)) begin
            f_cnt_d = '0;
            s_cnt_d = '0;
            state_d = ST_FILL;
          end else begin
            f_cnt_d = f_cnt_q + FAW'(1);
          end
        end
      end
      ST_FILL: begin
        if (f_xfer) begin
          f_cnt_d = FAW'(1);
          state_d = ST_FLOAD;
        end else if (s_xfer) begin
          if (s_cnt_q == SAW'(N - 1)) begin
            s_cnt_d = '0;
            i_d     = '0;
            k_d     = '0;
            state_d = ST_MAC;
          end else begin
            s_cnt_d = s_cnt_q + SAW'(1);
          end
        end
      end
      ST_MAC: begin
        k_d = k_q + KW'(1);
        if (k_q == KW'(1)) begin
          acc_d = AW'(prod);
        end else if (k_q > KW'(1) && k_q <= KW'(M)) begin
          acc_d = acc_q + AW'(prod);
        end
        if (k_q == KW'(M + 1)) begin
          out_d = sat_t;
`ifdef CONV_LAYER_RELU_EN
          if (sat_t < 0) begin
            out_d = '0;
          end
`endif
          k_d     = '0;
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (m_xfer) begin
          if (i_q == SAW'(N - M)) begin
            i_d     = '0;
            s_cnt_d = '0;
            state_d = ST_FILL;
          end else begin
            i_d     = i_q + SAW'(1);
            k_d     = '0;
            state_d = ST_MAC;
          end
        end
      end
      default: state_d = ST_FLOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FLOAD;
      run_q   <= 1'b0;
      f_cnt_q <= '0;
      s_cnt_q <= '0;
      i_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      f_cnt_q <= f_cnt_d;
      s_cnt_q <= s_cnt_d;
      i_q     <= i_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: doc/conv_layer_param.md
CONV_LAYER_PARAM -- requirements
Module: conv_layer_param

Interface
REQ-001 Parameter N, default 8: input vector length in samples; legal range M <= N <= 256.
REQ-002 Parameter M, default 4: filter taps; legal range 2 <= M <= 16.
REQ-003 Parameter T, default 8: signed sample, coefficient and output width; legal range 4 <= T <= 16.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; the block is in reset while reset = 0.
REQ-006 s_data_in  input  T  signed input sample. s_valid  input  1. s_ready  output  1.
REQ-007 f_data_in  input  T  signed coefficient. f_valid  input  1. f_ready  output  1.
REQ-008 m_data_out  output  T  signed result. m_valid  output  1. m_ready  input  1.
REQ-009 A transfer on any port occurs on a rising edge where its valid and ready are both 1.

Function
REQ-010 Output y[i] = sat(sum over j = 0..M-1 of x[i+j]*f[j]) for i = 0..N-M, in ascending i, N-M+1 outputs per input vector.
REQ-011 Arithmetic: products are signed 2T bits; the accumulator is 2T+clog2(M) bits; no intermediate truncation.
REQ-012 sat() clamps to the range -2^(T-1) .. 2^(T-1)-1.
REQ-013 FSM states: ST_FLOAD, ST_FILL, ST_MAC, ST_OUT; reset state is ST_FLOAD.
REQ-014 ST_FLOAD: f_ready = 1 and s_ready = 0; the block stores f[0..M-1] in arrival order; after the M-th coefficient transfer it goes to ST_FILL.
REQ-015 ST_FILL: s_ready = 1; the block stores x[0..N-1]; after the N-th sample transfer it goes to ST_MAC with i = 0.
REQ-016 Coefficient reload: in ST_FILL with zero samples received, f_ready = 1. When f_valid = 1 there, s_ready = 0 and the coefficient wins. Accepting a coefficient enters ST_FLOAD as f[0], so the block waits for M-1 more.
REQ-017 ST_MAC: one tap per cycle for M cycles through a 1-cycle synchronous memory read, then registers sat() into m_data_out and goes to ST_OUT.
REQ-018 Latency: m_valid rises exactly M+2 cycles after the last-sample transfer edge, and exactly M+2 cycles after each output transfer edge for i > 0.
REQ-019 ST_OUT: m_valid = 1. m_data_out and m_valid stay stable until the transfer. On the transfer, the block goes to ST_MAC with i+1, or to ST_FILL if i = N-M.
REQ-020 s_ready = 0 in ST_MAC and ST_OUT; f_ready = 0 except as stated in REQ-014 and REQ-016.
REQ-021 Coefficients persist across vectors until reloaded.

Reset
REQ-022 While reset = 0, the block asserts: s_ready = 0, f_ready = 0 and m_valid = 0. m_data_out = 0, the state is ST_FLOAD, and all counters = 0.
REQ-023 Reset at any point, including mid-ST_MAC or mid-ST_OUT, discards the partial vector, the outputs and the coefficients; no output transfer follows until a full reload.
REQ-024 Reset deassertion takes effect synchronously; f_ready rises on the first rising edge after reset = 1.

Configuration
REQ-025 Macro CONV_LAYER_RELU_EN defined: negative saturated results are replaced by 0 before m_data_out is registered.
REQ-026 Macro CONV_LAYER_RELU_EN undefined: results are output as saturated signed values; there is no ReLU logic; latency is identical in both cases.

Structure
REQ-027 Package conv_pkg holds:
- state enum typedef conv_state_t;
- default parameter constants CONV_N_DEF, CONV_M_DEF and CONV_T_DEF;
- saturation function conv_sat.
REQ-028 One sub-module, conv_param_mem: a parametrised single-write, synchronous-read memory instantiated twice, once for samples (depth N) and once for coefficients (depth M).

Verification
REQ-029 Defaults, ReLU off; f = 7, 5, -5, -6; x = 1..8 -> m_data_out = -22, -21, -20, -19, -18.
REQ-030 Same stimulus with CONV_LAYER_RELU_EN -> five outputs, all 0.
REQ-031 Saturation cases:
- f = 127 x4, x = 127 x8 -> five outputs of 127;
- f = -128 x4, x = 127 x8 -> five outputs of -128.
REQ-032 Backpressure: m_ready = 0 for 10 cycles at output i = 2 -> m_data_out = -20 held stable; the following outputs are unchanged; the first-output latency equals M+2 = 6 cycles.
REQ-033 Reset pulse mid-ST_MAC of i = 1 -> m_valid = 0 immediately. After reload with f = 1, 1, 1, 1 and x = 1..8, outputs are 10, 14, 18, 22, 26.
REQ-034 Reload with f_valid and s_valid both 1 at zero samples -> coefficient accepted, s_ready = 0. After the new f = 1, 0, 0, 0, x = 1..8 gives 1, 2, 3, 4, 5.
